multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 43 ++++
 rtl/multicycle_control_retire_counter.sv | 32 +++
 rtl/multicycle_control.sv | 179 +++++++++++++++++
 tb/tb_multicycle_control.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_pkg
// Description : Shared definitions for the multicycle datapath controller:
//               the FSM state encoding, the supported opcodes, the ALUOp
//               codes and the ALU B-operand select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        WB_MEM   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        WB_ALU   = 4'd8,
        BRANCH   = 4'd9,
        TRAP     = 4'd10
    } state_t;

    // Opcode field values of the supported instruction classes
    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    // ALUOp codes handed to the ALU control
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    // ALU B-operand select codes
    localparam logic [1:0] c_srcb_rs2  = 2'b00;
    localparam logic [1:0] c_srcb_four = 2'b01;
    localparam logic [1:0] c_srcb_imm  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_retire_counter.sv
`default_nettype none
// ============================================================================
// Module      : retire_counter
// Description : 32-bit retired-instruction counter. Increments by one on
//               every cycle in which inc is high and wraps naturally.
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset, clears the count
//               inc   - one retirement this cycle
//               count - current retired-instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module retire_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Main control FSM of a multicycle RISC-V style datapath.
//               Moore-decoded control strobes per state, memory wait
//               handling through mem_ready, illegal-opcode trap pulse and a
//               retired-instruction counter.
// Ports       : clk, rst_n          - clock, async active-low reset
//               opcode, zero        - IR opcode field, ALU zero flag
//               mem_ready           - memory access completes this cycle
//               mem_read, mem_write - memory strobes
//               ir_write, pc_write, reg_write - register enables
//               pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg - mux/ALU
//               illegal             - one-cycle unsupported-opcode pulse
//               instret             - retired instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic [31:0] instret
);

    state_t      r_state;
    state_t      w_next;
    logic [6:0]  r_opcode;

    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_ir_write;
    logic        w_pc_write;
    logic        w_reg_write;
    logic        w_illegal;
    logic        w_retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FETCH;
            r_opcode <= '0;
        end else begin
            r_state <= w_next;
            // Keep the opcode seen in DECODE so MEM_ADDR steers load/store
            // even if the IR field changes afterwards.
            if (r_state == DECODE) begin
                r_opcode <= opcode;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        w_retire    = 1'b0;
        pc_src      = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = c_srcb_rs2;
        alu_op      = c_aluop_add;
        mem_to_reg  = 1'b0;

        case (r_state)
            FETCH: begin
                w_mem_read = 1'b1;
                alu_src_b  = c_srcb_four;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = DECODE;
                end
            end
            DECODE: begin
                // Branch target PC + imm is computed here into ALUOut
                alu_src_b = c_srcb_imm;
                case (opcode)
                    c_op_r:                 w_next = EXEC_R;
                    c_op_i:                 w_next = EXEC_I;
                    c_op_load, c_op_store:  w_next = MEM_ADDR;
                    c_op_branch:            w_next = BRANCH;
                    default:                w_next = TRAP;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = c_srcb_imm;
                w_next    = (r_opcode == c_op_store) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_next = WB_MEM;
                end
            end
            WB_MEM: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 1'b1;
                w_retire    = 1'b1;
                w_next      = FETCH;
            end
            MEM_WR: begin
                w_mem_write = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = FETCH;
                end
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = c_srcb_rs2;
                alu_op    = c_aluop_funct;
                w_next    = WB_ALU;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = c_srcb_imm;
                alu_op    = c_aluop_funct;
                w_next    = WB_ALU;
            end
            WB_ALU: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = c_srcb_rs2;
                alu_op     = c_aluop_sub;
                pc_src     = 1'b1;
                w_pc_write = zero;
                w_retire   = 1'b1;
                w_next     = FETCH;
            end
            TRAP: begin
                w_illegal = 1'b1;
                w_next    = FETCH;
            end
            default: begin
                w_next = FETCH;
            end
        endcase
    end

    // The reset state FETCH would otherwise drive mem_read; gating with rst_n
    // keeps every strobe quiet for as long as reset is held, clock or not.
    assign mem_read  = w_mem_read  & rst_n;
    assign mem_write = w_mem_write & rst_n;
    assign ir_write  = w_ir_write  & rst_n;
    assign pc_write  = w_pc_write  & rst_n;
    assign reg_write = w_reg_write & rst_n;
    assign illegal   = w_illegal   & rst_n;

    retire_counter u_retire (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_retire),
        .count (instret)
    );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. Table of
//               instruction vectors with expected state sequences, plus
//               hand-written reset-mid-store and counter-wrap sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_read, mem_write, ir_write, pc_write, reg_write;
    logic        pc_src, alu_src_a, mem_to_reg, illegal;
    logic [1:0]  alu_src_b, alu_op;
    logic [31:0] instret;

    multicycle_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    logic [3:0]  dut_state;
    assign dut_state = dut.r_state;

    logic [12:0] act_ctl;
    assign act_ctl = {mem_read, mem_write, ir_write, pc_write, reg_write, pc_src,
                      alu_src_a, alu_src_b, alu_op, mem_to_reg, illegal};

    // seq holds one expected state per cycle, cycle 0 in the low nibble
    typedef struct packed {
        logic [6:0]  op;
        logic        z;
        logic [7:0]  rdy;
        logic [31:0] seq;
        logic [3:0]  len;
        logic        ret;
    } vec_t;

    localparam int NVEC = 8;
    vec_t        vecs [NVEC];
    int          tests  = 0;
    int          fails  = 0;
    logic [31:0] exp_instret;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected control word per state, written from the state/strobe table:
    // {mr, mw, irw, pcw, rw, pcs, asa, asb[1:0], aop[1:0], m2r, ill}
    function automatic logic [12:0] exp_ctl(input logic [3:0] st, input logic rdy, input logic z);
        case (st)
            4'd0:    exp_ctl = {1'b1, 1'b0, rdy, rdy, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
            4'd1:    exp_ctl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0};
            4'd2:    exp_ctl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0};
            4'd3:    exp_ctl = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
            4'd4:    exp_ctl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
            4'd5:    exp_ctl = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
            4'd6:    exp_ctl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0};
            4'd7:    exp_ctl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0};
            4'd8:    exp_ctl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
            4'd9:    exp_ctl = {1'b0, 1'b0, 1'b0, z,    1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0};
            4'd10:   exp_ctl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
            default: exp_ctl = '0;
        endcase
    endfunction

    // Runs one instruction starting in FETCH: inputs driven on the falling
    // edge, checks taken 1 ns later, final check just after the last rise.
    task automatic run_vec(input int idx, input vec_t vv);
        logic [3:0] es;
        opcode = vv.op;
        zero   = vv.z;
        for (int c = 0; c < int'(vv.len); c++) begin
            @(negedge clk);
            mem_ready = vv.rdy[c];
            #1;
            es = vv.seq[4*c +: 4];
            check($sformatf("v%0d c%0d state", idx, c), {28'd0, dut_state}, {28'd0, es});
            check($sformatf("v%0d c%0d ctl", idx, c), {19'd0, act_ctl},
                  {19'd0, exp_ctl(es, vv.rdy[c], vv.z)});
        end
        @(posedge clk);
        #1;
        exp_instret = exp_instret + {31'd0, vv.ret};
        check($sformatf("v%0d end state", idx), {28'd0, dut_state}, {28'd0, FETCH});
        check($sformatf("v%0d instret", idx), instret, exp_instret);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //             op          z     rdy    seq            len   ret
        vecs[0] = '{7'b0110011, 1'b0, 8'hFF, 32'h0000_8610, 4'd4, 1'b1}; // R-type
        vecs[1] = '{7'b0010011, 1'b0, 8'hFF, 32'h0000_8710, 4'd4, 1'b1}; // I-type
        vecs[2] = '{7'b0000011, 1'b0, 8'h67, 32'h0433_3210, 4'd7, 1'b1}; // load, 2 waits
        vecs[3] = '{7'b0100011, 1'b0, 8'hFF, 32'h0000_5210, 4'd4, 1'b1}; // store
        vecs[4] = '{7'b1100011, 1'b1, 8'hFF, 32'h0000_0910, 4'd3, 1'b1}; // beq taken
        vecs[5] = '{7'b1100011, 1'b0, 8'hFF, 32'h0000_0910, 4'd3, 1'b1}; // beq not taken
        vecs[6] = '{7'b1111111, 1'b0, 8'hFF, 32'h0000_0A10, 4'd3, 1'b0}; // illegal
        vecs[7] = '{7'b0110011, 1'b0, 8'hFE, 32'h0008_6100, 4'd5, 1'b1}; // fetch wait

        rst_n       = 1'b0;
        opcode      = 7'b0110011;
        zero        = 1'b0;
        mem_ready   = 1'b1;
        exp_instret = 32'd0;

        // Reset state: clock running, strobes held low
        repeat (3) @(negedge clk);
        check("reset state", {28'd0, dut_state}, {28'd0, FETCH});
        check("reset ctl", {19'd0, act_ctl}, {19'd0, 13'b0_0000_0001_0000});
        check("reset instret", instret, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int v = 0; v < NVEC; v++) begin
            run_vec(v, vecs[v]);
        end

        // Asynchronous reset in the middle of a store memory wait
        opcode = 7'b0100011;
        zero   = 1'b0;
        @(negedge clk); mem_ready = 1'b1;   // FETCH
        @(negedge clk);                     // DECODE
        @(negedge clk);                     // MEM_ADDR
        @(negedge clk); mem_ready = 1'b0;   // MEM_WR, waiting
        #1;
        check("mid-store state", {28'd0, dut_state}, {28'd0, MEM_WR});
        check("mid-store mem_write", {31'd0, mem_write}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        exp_instret = 32'd0;
        check("async rst mem_write", {31'd0, mem_write}, 32'd0);
        check("async rst mem_read", {31'd0, mem_read}, 32'd0);
        check("async rst state", {28'd0, dut_state}, {28'd0, FETCH});
        check("async rst instret", instret, 32'd0);
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        rst_n     = 1'b1;

        // Counter wrap: preset to all ones, one store retires
        force dut.u_retire.r_count = 32'hFFFF_FFFF;
        #1;
        release dut.u_retire.r_count;
        check("preset instret", instret, 32'hFFFF_FFFF);
        exp_instret = 32'hFFFF_FFFF;
        run_vec(8, vecs[3]);
        check("wrap instret zero", instret, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
